// File: rtl/fhe_alu_pkg.sv
// Shared sizing for the FHE ALU Benes interconnect plus the config-sequencer types.
package FHE_ALU_PKG;
  localparam int SIZE       = 32;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
  localparam int STAGE_W    = $clog2(STAGE_NUM);

  // Stage 0 is the leftmost (most significant) row.
  typedef logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] select_t;

  typedef struct packed {
    select_t module_rows;
    select_t slot_rows;
  } cfg_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;
endpackage

// File: rtl/benes_cfg_table.sv
// Switch-configuration store: one row written per cycle, whole entry read registered.
module benes_cfg_table
  import FHE_ALU_PKG::*;
#(
  parameter int CFG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(CFG_DEPTH)-1:0] wr_addr,
  input  logic                         wr_sel,
  input  logic [STAGE_W-1:0]           wr_stage,
  input  logic [SWITCH_NUM-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(CFG_DEPTH)-1:0] rd_addr,
  output cfg_entry_t                   rd_data
);
  cfg_entry_t mem [CFG_DEPTH];

  // Non-blocking read of mem gives pre-write data on a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && (int'(wr_stage) < STAGE_NUM)) begin
        if (wr_sel) mem[wr_addr].slot_rows[wr_stage]   <= wr_data;
        else        mem[wr_addr].module_rows[wr_stage] <= wr_data;
      end
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/benes_cfg_sequencer.sv
// Loads a stored Benes switch configuration, issues a burst of beats, waits out the network latency.
module benes_cfg_sequencer
  import FHE_ALU_PKG::*;
#(
  parameter int CFG_DEPTH   = 16,
  parameter int NET_LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cfg_wr_en,
  input  logic [$clog2(CFG_DEPTH)-1:0] i_cfg_wr_addr,
  input  logic                         i_cfg_wr_sel,
  input  logic [STAGE_W-1:0]           i_cfg_wr_stage,
  input  logic [SWITCH_NUM-1:0]        i_cfg_wr_data,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [$clog2(CFG_DEPTH)-1:0] i_cmd_idx,
  input  logic [7:0]                   i_cmd_len,
  input  logic                         i_hold,
  output select_t                      o_module_select,
  output select_t                      o_slot_select,
  output logic                         o_beat_valid,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int DW = ($clog2(NET_LATENCY + 1) < 1) ? 1 : $clog2(NET_LATENCY + 1);

  seq_state_t      state, state_nxt;
  logic [7:0]      cnt;
  logic [DW-1:0]   drain_cnt;
  logic            cmd_fire;
  logic            beat;
  cfg_entry_t      rd_data;

  // Ready drops during the done cycle so a held request starts one cycle after o_done.
  assign o_cmd_ready  = rst_n && (state == ST_IDLE) && !o_done;
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign o_beat_valid = beat;
  assign o_busy       = (state != ST_IDLE);

  benes_cfg_table #(.CFG_DEPTH(CFG_DEPTH)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (i_cfg_wr_en),
    .wr_addr  (i_cfg_wr_addr),
    .wr_sel   (i_cfg_wr_sel),
    .wr_stage (i_cfg_wr_stage),
    .wr_data  (i_cfg_wr_data),
    .rd_en    (cmd_fire),
    .rd_addr  (i_cmd_idx),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    unique case (state)
      ST_IDLE:  if (cmd_fire) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (cnt == 8'd0) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: if (!i_hold) begin
        beat = 1'b1;
        if (cnt == 8'd1) state_nxt = (NET_LATENCY == 0) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DW'(NET_LATENCY - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      drain_cnt       <= '0;
      o_done          <= 1'b0;
      o_module_select <= '0;
      o_slot_select   <= '0;
    end else begin
      state  <= state_nxt;
      o_done <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      if (cmd_fire) cnt <= i_cmd_len;
      else if (beat) cnt <= cnt - 8'd1;
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                   drain_cnt <= '0;
      if (state == ST_LOAD) begin
        o_module_select <= rd_data.module_rows;
        o_slot_select   <= rd_data.slot_rows;
      end
    end
  end
endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Directed checks of the Benes config sequencer: timing, hold, zero length, writes, reset, back-to-back.
module tb_benes_cfg_sequencer;
  import FHE_ALU_PKG::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_cfg_wr_en;
  logic [3:0]      i_cfg_wr_addr;
  logic            i_cfg_wr_sel;
  logic [STAGE_W-1:0] i_cfg_wr_stage;
  logic [SWITCH_NUM-1:0] i_cfg_wr_data;
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic [3:0]      i_cmd_idx;
  logic [7:0]      i_cmd_len;
  logic            i_hold;
  select_t         o_module_select, o_slot_select;
  logic            o_beat_valid, o_busy, o_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] beat_mask, done_mask, busy_mask, ready_mask;
  select_t     mod_c1, mod_c2, slot_c2, exp_mod, exp_slot;

  benes_cfg_sequencer #(.CFG_DEPTH(16), .NET_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_wr_en(i_cfg_wr_en), .i_cfg_wr_addr(i_cfg_wr_addr), .i_cfg_wr_sel(i_cfg_wr_sel),
    .i_cfg_wr_stage(i_cfg_wr_stage), .i_cfg_wr_data(i_cfg_wr_data),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_idx(i_cmd_idx),
    .i_cmd_len(i_cmd_len), .i_hold(i_hold),
    .o_module_select(o_module_select), .o_slot_select(o_slot_select),
    .o_beat_valid(o_beat_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int addr, input bit sel, input int stage, input logic [15:0] data);
    i_cfg_wr_en = 1'b1; i_cfg_wr_addr = 4'(addr); i_cfg_wr_sel = sel;
    i_cfg_wr_stage = STAGE_W'(stage); i_cfg_wr_data = data;
    next_cyc();
    i_cfg_wr_en = 1'b0;
  endtask

  // Cycle 0 is the accept cycle; one optional table write on cycle wr_c.
  task automatic run(input int idx, input int len, input logic [31:0] vld_m,
                     input logic [31:0] hold_m, input int ncyc, input int wr_c,
                     input bit wsel, input int wstage, input logic [15:0] wdata);
    beat_mask = '0; done_mask = '0; busy_mask = '0; ready_mask = '0;
    for (int c = 0; c < ncyc; c++) begin
      i_cmd_valid = vld_m[c]; i_cmd_idx = 4'(idx); i_cmd_len = 8'(len); i_hold = hold_m[c];
      i_cfg_wr_en = (c == wr_c); i_cfg_wr_addr = 4'(idx); i_cfg_wr_sel = wsel;
      i_cfg_wr_stage = STAGE_W'(wstage); i_cfg_wr_data = wdata;
      @(negedge clk);
      beat_mask[c] = o_beat_valid; done_mask[c] = o_done;
      busy_mask[c] = o_busy;       ready_mask[c] = o_cmd_ready;
      if (c == 1) mod_c1 = o_module_select;
      if (c == 2) begin mod_c2 = o_module_select; slot_c2 = o_slot_select; end
      next_cyc();
    end
    i_cmd_valid = 1'b0; i_hold = 1'b0; i_cfg_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_cfg_wr_en = 1'b0; i_cfg_wr_addr = '0; i_cfg_wr_sel = 1'b0;
    i_cfg_wr_stage = '0; i_cfg_wr_data = '0; i_cmd_valid = 1'b1; i_cmd_idx = '0;
    i_cmd_len = 8'd1; i_hold = 1'b0;

    // Reset state, with a request already pending.
    @(negedge clk);
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_beat",  o_beat_valid, 0);
    chk("rst_sel",   {o_module_select, o_slot_select}, 0);
    i_cmd_valid = 1'b0;
    next_cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", o_cmd_ready, 1);
    next_cyc();

    // Basic command: entry 3, len 4.
    for (int s = 0; s < STAGE_NUM; s++) wr(3, 1'b0, s, 16'hA5A5);
    for (int s = 0; s < STAGE_NUM; s++) wr(3, 1'b1, s, 16'h5A5A);
    for (int s = 0; s < STAGE_NUM; s++) begin exp_mod[s] = 16'hA5A5; exp_slot[s] = 16'h5A5A; end
    run(3, 4, 32'h1, 32'h0, 12, -1, 0, 0, 0);
    chk("t1_sel_c1",   mod_c1, 0);
    chk("t1_mod_c2",   mod_c2, exp_mod);
    chk("t1_slot_c2",  slot_c2, exp_slot);
    chk("t1_beats",    beat_mask, 32'h0000_003C);
    chk("t1_done",     done_mask, 32'h0000_0200);
    chk("t1_busy",     busy_mask, 32'h0000_01FE);
    chk("t1_ready",    ready_mask, 32'h0000_0C01);

    // Hold on cycles 3 and 4.
    run(3, 4, 32'h1, 32'h18, 13, -1, 0, 0, 0);
    chk("t2_beats", beat_mask, 32'h0000_00E4);
    chk("t2_done",  done_mask, 32'h0000_0800);

    // Zero-length command on entry 5.
    wr(5, 1'b0, 0, 16'h1234);
    wr(5, 1'b1, 8, 16'hBEEF);
    run(5, 0, 32'h1, 32'h0, 4, -1, 0, 0, 0);
    exp_mod = '0; exp_mod[0] = 16'h1234;
    exp_slot = '0; exp_slot[8] = 16'hBEEF;
    chk("t3_beats", beat_mask, 0);
    chk("t3_done",  done_mask, 32'h4);
    chk("t3_mod",   mod_c2, exp_mod);
    chk("t3_slot",  slot_c2, exp_slot);
    chk("t3_hold_idle", o_module_select, exp_mod);

    // Write to the active entry mid-ISSUE, then a same-cycle write/read collision.
    for (int s = 0; s < STAGE_NUM; s++) exp_mod[s] = 16'hA5A5;
    run(3, 4, 32'h1, 32'h0, 11, 3, 1'b0, 0, 16'hFFFF);
    chk("t4_sel_unchanged", o_module_select, exp_mod);
    run(3, 1, 32'h1, 32'h0, 8, 0, 1'b0, 1, 16'h0000);
    exp_mod[0] = 16'hFFFF;
    chk("t4_new_data", mod_c2, exp_mod);
    chk("t4_beats", beat_mask, 32'h4);
    chk("t4_done",  done_mask, 32'h40);
    run(3, 0, 32'h1, 32'h0, 4, -1, 0, 0, 0);
    exp_mod[1] = 16'h0000;
    chk("t4_collide_later", mod_c2, exp_mod);

    // Reset during DRAIN.
    run(3, 1, 32'h1, 32'h0, 4, -1, 0, 0, 0);
    chk("t5_in_drain", busy_mask, 32'hE);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_done",  o_done, 0);
    chk("t5_rst_busy",  o_busy, 0);
    chk("t5_rst_ready", o_cmd_ready, 0);
    chk("t5_rst_beat",  o_beat_valid, 0);
    chk("t5_rst_sel",   {o_module_select, o_slot_select}, 0);
    next_cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", o_cmd_ready, 1);
    chk("t5_no_done",     o_done, 0);
    next_cyc();
    @(negedge clk);
    chk("t5_no_done2", o_done, 0);
    next_cyc();
    for (int s = 0; s < STAGE_NUM; s++) wr(3, 1'b0, s, 16'hA5A5);
    run(4, 0, 32'h1, 32'h0, 4, -1, 0, 0, 0);
    chk("t5_table_cleared", mod_c2, 0);

    // Valid held high across a busy command.
    run(3, 1, 32'hFFFF_FFFF, 32'h0, 14, -1, 0, 0, 0);
    chk("t6_ready", ready_mask, 32'h0000_0081);
    chk("t6_beats", beat_mask,  32'h0000_0204);
    chk("t6_done",  done_mask,  32'h0000_2040);
    for (int c = 0; c < 3; c++) next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
